muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Execute-stage HI/LO unit, directly downstream of instruction decode.
- Consumes the decoder's is_mult/is_multu/is_div/is_divu/lo_wen/hi_wen strobes together with operand data.
- Owns the architectural HI and LO registers, a pipelined 32x32 multiplier and an iterative radix-2 divider.
- Raises busy so the pipeline stalls any later mfhi/mflo/muldiv until results land.

Parameters:
- MUL_STAGES, 2: cycles from multiply acceptance to HI/LO write; legal range 1-4.
- DIV_ITERS, 32: radix-2 iterations per divide; fixed at 32, exposed only for bench shortening.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  ID/EX instruction valid and not stalled
- is_mult  in  1  signed multiply (also set for mul)
- is_multu  in  1  unsigned multiply
- is_div  in  1  signed divide
- is_divu  in  1  unsigned divide
- hi_wen  in  1  mthi
- lo_wen  in  1  mtlo
- mul_to_gpr  in  1  mul form: product goes to GPR only, HI/LO untouched
- a  in  32  rs_data
- b  in  32  rt_data
- cancel  in  1  exception/eret flush of the in-flight op
- busy  out  1  op in flight; the accepting stage must stall
- done  out  1  one-cycle pulse when a mul/div result is written
- hi  out  32  HI register
- lo  out  32  LO register
- product  out  32  low product word for mul_to_gpr, valid while done

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, product=0; state IDLE; any operation in flight is discarded.
- Acceptance: an op is accepted when start & ~busy & ~cancel. start while busy is ignored, because upstream holds the instruction. At most one of the op strobes is set; if none is set, start is a no-op.
- mthi/mtlo: write hi/lo at the accepting edge. busy stays 0 and done stays 0.
- States:
  - IDLE: on multiply -> MUL; on divide -> DIV_INIT.
  - MUL: runs MUL_STAGES cycles. Operands are extended to 33 bits (sign-extended for mult, zero-extended for multu). On the final cycle write {hi,lo} = product[63:0] (skipped if mul_to_gpr), drive product = product[31:0], pulse done, return to IDLE.
  - DIV_INIT (1 cycle): latch |a| and |b|, plus the quotient sign (a[31]^b[31]) and the remainder sign (a[31]); signs are used only for div.
  - DIV_ITER: DIV_ITERS cycles of restoring shift-subtract on the magnitudes, with a 6-bit iteration counter.
  - DIV_FIX (1 cycle): negate quotient/remainder as required; lo = quotient, hi = remainder; pulse done; return to IDLE.
- Timing: busy is 1 from the cycle after acceptance until the cycle done is asserted, inclusive.
  - Multiply latency is MUL_STAGES.
  - Divide latency is DIV_ITERS+2 = 34.
- Divide by zero: no exception. The natural restoring result is written: lo = 0xFFFFFFFF and hi = dividend magnitude, with sign fixup applied for div.
- 0x80000000 / 0xFFFFFFFF with div gives lo = 0x80000000, hi = 0; no trap.
- cancel: in any non-IDLE state, return to IDLE on the next edge. hi/lo are not written, done is not pulsed, and busy falls the following cycle. cancel in the same cycle as start suppresses acceptance, including for mthi/mtlo.
- cancel in the same cycle as the final MUL or DIV_FIX state: cancel wins and there is no write.
- reset overrides everything, mid-operation included.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN, when defined: in DIV_INIT, if |b| > |a| (b != 0), skip DIV_ITER and go straight to DIV_FIX with quotient = 0 and remainder = |a|. Latency is 2 cycles. If |a| == 0 and b != 0, latency is also 2 cycles and the result is 0/0.
- When undefined: every divide takes 34 cycles. Results are bit-identical either way.

Decomposition:
- Shared header muldiv.vh holds:
  - state encodings: IDLE, MUL, DIV_INIT, DIV_ITER, DIV_FIX;
  - the op one-hot order {divu, div, multu, mult};
  - the DIV_LATENCY constant.
- Sub-module div_radix2 contains the iterative magnitude divider: start/done handshake, cancel input, and quotient/remainder outputs.
- The top level keeps the FSM, sign handling, the multiplier pipeline and the HI/LO registers.

Test Plan:
- Reset then mthi 0x12345678, next cycle mtlo 0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy never 1.
- mult a=0xFFFFFFFE (-2), b=3 -> done at cycle 2; hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- mul (is_mult & mul_to_gpr) 7x6 with hi/lo preloaded to 0xAAAAAAAA -> product=42 with done; hi/lo remain 0xAAAAAAAA.
- div a=-7 (0xFFFFFFF9), b=2 -> busy for 34 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100/0 -> lo=0xFFFFFFFF, hi=100.
- divu 1000/7 with cancel asserted at iteration 10 -> busy drops, no done pulse, hi/lo unchanged. A new divu 10/3 accepted next -> lo=3, hi=1.
- With MULDIV_EARLY_OUT_EN: divu 5/9 -> done 2 cycles after acceptance, lo=0, hi=5. Without the macro the same op takes 34 cycles.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM state encodings,
// op one-hot bit positions, divide latency and a conditional-negate helper.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_DIV_INIT = 3'd2,
    ST_DIV_ITER = 3'd3,
    ST_DIV_FIX  = 3'd4
  } state_e;

  // Bit positions within the op one-hot {divu, div, multu, mult}
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;

  localparam int DIV_LATENCY = 34;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    if (neg) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// Iterative restoring radix-2 divider on 32-bit magnitudes, one quotient bit per
// cycle. o_done marks the final iteration; results are valid from the next cycle.
module div_radix2
  import muldiv_unit_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_cancel,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  localparam logic [5:0] LAST = 6'(ITERS - 1);

  logic        r_run;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;

  logic [32:0] w_shift;
  logic        w_fits;
  logic [31:0] w_diff;

  // rem < divisor always holds, so a successful subtract fits in 32 bits
  assign w_shift = {r_rem, r_quo[31]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[31:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run <= 1'b0;
      r_cnt <= 6'd0;
      r_rem <= 32'd0;
      r_quo <= 32'd0;
      r_dvs <= 32'd0;
    end else if (i_cancel) begin
      r_run <= 1'b0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= 6'd0;
      r_rem <= 32'd0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (r_run) begin
      r_rem <= w_fits ? w_diff : w_shift[31:0];
      r_quo <= {r_quo[30:0], w_fits};
      r_cnt <= r_cnt + 6'd1;
      r_run <= (r_cnt != LAST);
    end
  end

  assign o_done      = r_run && (r_cnt == LAST);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage HI/LO unit: owns HI/LO, a multiplier and an iterative divider.
// Optional macro MULDIV_EARLY_OUT_EN skips iteration when |b| > |a|.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic        mul_to_gpr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] product
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES);

  state_e      r_state;
  state_e      w_state_n;
  logic [2:0]  r_cnt;
  logic [32:0] r_xa;
  logic [32:0] r_xb;
  logic        r_sdiv;
  logic        r_gpr;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_early;
  logic [31:0] r_early_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [3:0]  w_op;
  logic        w_is_mul;
  logic        w_is_dv;
  logic        w_accept;
  logic        w_mul_final;
  logic        w_done;
  logic [63:0] w_xa64;
  logic [63:0] w_xb64;
  logic [63:0] w_prod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_early;
  logic        w_div_start;
  logic        w_div_last;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  assign w_op     = {is_divu, is_div, is_multu, is_mult};
  assign w_is_mul = w_op[OP_MULT] | w_op[OP_MULTU];
  assign w_is_dv  = w_op[OP_DIV] | w_op[OP_DIVU];
  assign busy     = (r_state != ST_IDLE);
  assign w_accept = start & ~busy & ~cancel;

  // Low 64 bits of the 33x33 product, computed from the 64-bit sign extension
  assign w_xa64  = {{31{r_xa[32]}}, r_xa};
  assign w_xb64  = {{31{r_xb[32]}}, r_xb};
  assign w_prod  = w_xa64 * w_xb64;
  assign product = w_prod[31:0];

  assign w_mul_final = (r_state == ST_MUL) && (r_cnt == MUL_LAST);
  assign w_abs_a     = cond_neg(r_xa[31:0], r_sdiv & r_xa[31]);
  assign w_abs_b     = cond_neg(r_xb[31:0], r_sdiv & r_xb[31]);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = (w_abs_b != 32'd0) && (w_abs_b > w_abs_a);
`else
  assign w_early = 1'b0;
`endif

  assign w_div_start = (r_state == ST_DIV_INIT) & ~cancel & ~w_early;
  assign w_q_mag     = r_early ? 32'd0 : w_div_q;
  assign w_r_mag     = r_early ? r_early_rem : w_div_r;

  div_radix2 #(.ITERS(DIV_ITERS)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_cancel   (cancel),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_done     (w_div_last),
    .o_quotient (w_div_q),
    .o_remainder(w_div_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state; done is qualified by ~cancel so a flush in the last cycle wins
  always_comb begin
    w_state_n = r_state;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_n = ST_MUL;
        end else if (w_accept && w_is_dv) begin
          w_state_n = ST_DIV_INIT;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cancel) begin
          w_state_n = ST_IDLE;
        end else if (w_mul_final) begin
          w_done    = 1'b1;
          w_state_n = ST_IDLE;
        end else begin
          w_state_n = ST_MUL;
        end
      end
      ST_DIV_INIT: begin
        if (cancel) begin
          w_state_n = ST_IDLE;
        end else if (w_early) begin
          w_state_n = ST_DIV_FIX;
        end else begin
          w_state_n = ST_DIV_ITER;
        end
      end
      ST_DIV_ITER: begin
        if (cancel) begin
          w_state_n = ST_IDLE;
        end else if (w_div_last) begin
          w_state_n = ST_DIV_FIX;
        end else begin
          w_state_n = ST_DIV_ITER;
        end
      end
      ST_DIV_FIX: begin
        if (cancel) begin
          w_state_n = ST_IDLE;
        end else begin
          w_done    = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign done = w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 3'd0;
      r_xa        <= 33'd0;
      r_xb        <= 33'd0;
      r_sdiv      <= 1'b0;
      r_gpr       <= 1'b0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_early     <= 1'b0;
      r_early_rem <= 32'd0;
    end else begin
      if (w_accept && (w_is_mul || w_is_dv)) begin
        r_xa   <= {is_mult & a[31], a};
        r_xb   <= {is_mult & b[31], b};
        r_sdiv <= is_div;
        r_gpr  <= mul_to_gpr;
        r_cnt  <= 3'd1;
      end else if (r_state == ST_MUL) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == ST_DIV_INIT) begin
        r_qneg      <= r_sdiv & (r_xa[31] ^ r_xb[31]);
        r_rneg      <= r_sdiv & r_xa[31];
        r_early     <= w_early;
        r_early_rem <= w_abs_a;
      end
    end
  end

  // Architectural HI/LO: mthi/mtlo at acceptance, results on the done cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (w_accept && hi_wen) begin
        r_hi <= a;
      end else if (w_done && (r_state == ST_MUL) && !r_gpr) begin
        r_hi <= w_prod[63:32];
      end else if (w_done && (r_state == ST_DIV_FIX)) begin
        r_hi <= cond_neg(w_r_mag, r_rneg);
      end
      if (w_accept && lo_wen) begin
        r_lo <= a;
      end else if (w_done && (r_state == ST_MUL) && !r_gpr) begin
        r_lo <= w_prod[31:0];
      end else if (w_done && (r_state == ST_DIV_FIX)) begin
        r_lo <= cond_neg(w_q_mag, r_qneg);
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expectations, a monitor
// pops and checks on every done pulse (latency, product, then HI/LO).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, is_mult, is_multu, is_div, is_divu;
  logic        hi_wen, lo_wen, mul_to_gpr, cancel;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo, product;

  muldiv_unit #(.MUL_STAGES(2), .DIV_ITERS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_mult(is_mult), .is_multu(is_multu),
    .is_div(is_div), .is_divu(is_divu), .hi_wen(hi_wen), .lo_wen(lo_wen),
    .mul_to_gpr(mul_to_gpr), .a(a), .b(b), .cancel(cancel), .busy(busy),
    .done(done), .hi(hi), .lo(lo), .product(product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] prod;
    bit          chk_prod;
    int          lat;
    int          issue_cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops on done, HI/LO compared one cycle later once written
  int   busy_len = 0;
  bit   pend     = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (reset) begin
      busy_len = 0;
      pend     = 1'b0;
    end else begin
      if (pend) begin
        check32({cur.name, " hi"}, hi, cur.hi);
        check32({cur.name, " lo"}, lo, cur.lo);
        pend = 1'b0;
      end
      if (busy) busy_len++;
      else busy_len = 0;
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with no op expected", cyc);
        end else begin
          cur = sbq.pop_front();
          check_int({cur.name, " busy_cycles"}, busy_len, cur.lat);
          check_int({cur.name, " done_cycle"}, cyc, cur.issue_cyc + cur.lat);
          if (cur.chk_prod) check32({cur.name, " product"}, product, cur.prod);
          pend = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    start = 1'b0; is_mult = 1'b0; is_multu = 1'b0; is_div = 1'b0; is_divu = 1'b0;
    hi_wen = 1'b0; lo_wen = 1'b0; mul_to_gpr = 1'b0; cancel = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check_int("idle_wait_busy", int'(busy), 0);
  endtask

  // op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
  task automatic issue(input string nm, input int op, input logic gpr,
                       input logic [31:0] va, input logic [31:0] vb, input bit push,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic [31:0] eprod, input bit cp, input int lat);
    exp_t e;
    wait_idle();
    start = 1'b1; a = va; b = vb; mul_to_gpr = gpr;
    case (op)
      0: is_mult  = 1'b1;
      1: is_multu = 1'b1;
      2: is_div   = 1'b1;
      3: is_divu  = 1'b1;
      4: hi_wen   = 1'b1;
      5: lo_wen   = 1'b1;
      default: start = 1'b0;
    endcase
    if (push) begin
      e.hi = ehi; e.lo = elo; e.prod = eprod; e.chk_prod = cp;
      e.lat = lat; e.issue_cyc = cyc; e.name = nm;
      sbq.push_back(e);
    end
    tick();
    clear_ctl();
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || pend) && n < 200) begin
      tick();
      n++;
    end
    check_int("scoreboard_drain", sbq.size(), 0);
  endtask

  initial begin
    clear_ctl();
    a = 32'd0; b = 32'd0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check32("reset hi", hi, 32'd0);
    check32("reset lo", lo, 32'd0);
    check32("reset product", product, 32'd0);
    check_int("reset busy", int'(busy), 0);
    check_int("reset done", int'(done), 0);

    // mthi / mtlo never raise busy or done
    issue("mthi", 4, 1'b0, 32'h12345678, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    check_int("mthi busy", int'(busy), 0);
    issue("mtlo", 5, 1'b0, 32'h9ABCDEF0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      check_int("mt busy", int'(busy), 0);
      check_int("mt done", int'(done), 0);
      tick();
    end
    check32("mthi hi", hi, 32'h12345678);
    check32("mtlo lo", lo, 32'h9ABCDEF0);

    // cancel in the same cycle as start suppresses mthi
    start = 1'b1; hi_wen = 1'b1; a = 32'hDEADBEEF; cancel = 1'b1;
    tick();
    clear_ctl();
    check32("mthi_cancelled hi", hi, 32'h12345678);

    issue("mult", 0, 1'b0, 32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFA, 1'b1, 2);
    issue("multu", 1, 1'b0, 32'hFFFFFFFE, 32'd3, 1'b1, 32'h00000002, 32'hFFFFFFFA, 32'hFFFFFFFA, 1'b1, 2);
    issue("mthi_pre", 4, 1'b0, 32'hAAAAAAAA, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    issue("mtlo_pre", 5, 1'b0, 32'hAAAAAAAA, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    issue("mul_gpr", 0, 1'b1, 32'd7, 32'd6, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'd42, 1'b1, 2);

    // cancel in the final MUL cycle: no done, no write
    issue("mult_cancel", 0, 1'b0, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    tick();
    check_int("mul_final busy", int'(busy), 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_int("mul_cancel busy", int'(busy), 0);
    check32("mul_cancel hi", hi, 32'hAAAAAAAA);
    check32("mul_cancel lo", lo, 32'hAAAAAAAA);

    issue("div_m7_2", 2, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 1'b0, 34);
    issue("divu_100_0", 3, 1'b0, 32'd100, 32'd0, 1'b1, 32'd100, 32'hFFFFFFFF, 32'h0, 1'b0, 34);
    issue("div_m7_0", 2, 1'b0, 32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFF9, 32'h00000001, 32'h0, 1'b0, 34);
    issue("div_min_m1", 2, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 32'h0, 1'b0, 34);

    // cancel at iteration 10 of divu 1000/7
    issue("divu_cancel", 3, 1'b0, 32'd1000, 32'd7, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    repeat (10) tick();
    check_int("div_iter busy", int'(busy), 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_int("div_cancel busy", int'(busy), 0);
    repeat (3) tick();
    check_int("div_cancel busy_later", int'(busy), 0);
    check32("div_cancel hi", hi, 32'h0);
    check32("div_cancel lo", lo, 32'h80000000);

    issue("divu_10_3", 3, 1'b0, 32'd10, 32'd3, 1'b1, 32'd1, 32'd3, 32'h0, 1'b0, 34);
    issue("divu_5_9", 3, 1'b0, 32'd5, 32'd9, 1'b1, 32'd5, 32'd0, 32'h0, 1'b0, EARLY_LAT);
    issue("divu_0_5", 3, 1'b0, 32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 32'h0, 1'b0, EARLY_LAT);
    wait_idle();
    drain();

    // reset in the middle of a divide discards it
    issue("divu_reset", 3, 1'b0, 32'd50, 32'd5, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_int("midop_reset busy", int'(busy), 0);
    check_int("midop_reset done", int'(done), 0);
    check32("midop_reset hi", hi, 32'h0);
    check32("midop_reset lo", lo, 32'h0);
    repeat (40) tick();
    check_int("midop_reset busy_later", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
